// File: rtl/usb_event_ctrl.sv
// ---------------------------------------------------------------------------
// usb_event_ctrl
//
// Sideband event controller for the USB host chip. The INT and GPX pins are
// synchronized, glitch-filtered, and edge-detected into sticky EDGE bits.
// Each EDGE bit can be masked into a level IRQ for the Nios II. STATUS reports
// the highest-priority enabled pending source, so the ISR can dispatch
// directly. INT (source 0) has priority over GPX (source 1).
//
// Optional feature macro: USB_EVT_TIMESTAMP_EN
//    When this macro is defined, a free-running TS_WIDTH counter is built.
//    The first edge captured on each source latches the counter value into
//    TS_INT (address 5) or TS_GPX (address 6). When the macro is undefined,
//    both addresses read 0.
//
// Ports:
//    clk         system clock
//    reset_n     asynchronous active-low reset
//    usb_int     raw INT pin (asynchronous)
//    usb_gpx     raw GPX pin (asynchronous)
//    address     Avalon word address (0..7)
//    chipselect  slave select
//    read        read strobe (readdata valid one clock later)
//    write_n     active-low write strobe
//    writedata   write data
//    readdata    registered read data, held between reads
//    irq         registered level interrupt, |(EDGE & MASK)
// ---------------------------------------------------------------------------
module usb_event_ctrl #(
   parameter int FILTER_CYCLES = 4,
   parameter int TS_WIDTH      = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        usb_int,
   input  logic        usb_gpx,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] r_level;
   logic [1:0] r_levelPrev;
   logic [7:0] r_filtCnt [2];
   logic [1:0] r_mask;
   logic [1:0] r_edge;
   logic [1:0] r_ctrl;
   logic       r_overrun;

   logic [1:0]  w_edgeDet;
   logic [1:0]  w_edgeClr;
   logic [1:0]  w_pend;
   logic [1:0]  w_id;
   logic        w_wr;
   logic        w_rd;
   logic        w_ovClr;
   logic [31:0] w_rdMux;
   logic        w_unused;

   assign w_wr      = chipselect & ~write_n;
   assign w_rd      = chipselect & read;
   assign w_edgeClr = (w_wr && address == 3'd2) ? writedata[1:0] : 2'b00;
   assign w_ovClr   = w_wr && address == 3'd4 && writedata[3];
   assign w_pend    = r_edge & r_mask;
   // INT wins whenever it is pending, so the id is 1 only for GPX-alone.
   assign w_id      = {1'b0, ~w_pend[0] & w_pend[1]};
   assign w_unused  = ^writedata[31:4];

   // Two-flop synchronizer per pin; bit index is the source index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
      end else begin
         r_sync1 <= {usb_gpx, usb_int};
         r_sync2 <= r_sync1;
      end
   end

   // Glitch filter: the filtered level only follows the synchronized value
   // after FILTER_CYCLES consecutive clocks of disagreement.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_level     <= 2'b00;
         r_levelPrev <= 2'b00;
         for (int i = 0; i < 2; i++) r_filtCnt[i] <= 8'd0;
      end else begin
         r_levelPrev <= r_level;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_level[i]) begin
               r_filtCnt[i] <= 8'd0;
            end else if (r_filtCnt[i] == FILT_LAST) begin
               r_level[i]   <= r_sync2[i];
               r_filtCnt[i] <= 8'd0;
            end else begin
               r_filtCnt[i] <= r_filtCnt[i] + 8'd1;
            end
         end
      end
   end

   // The edge detector compares registered levels, so a CTRL change by itself
   // never looks like an edge.
   always_comb begin
      w_edgeDet = 2'b00;
      for (int i = 0; i < 2; i++) begin
         w_edgeDet[i] = r_ctrl[i] ? (r_levelPrev[i] & ~r_level[i])
                                  : (~r_levelPrev[i] & r_level[i]);
      end
   end

   // Control and event registers. A new edge takes priority over a
   // same-cycle W1C, so the event is not lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask    <= 2'b00;
         r_ctrl    <= 2'b00;
         r_edge    <= 2'b00;
         r_overrun <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (w_wr && address == 3'd1) r_mask <= writedata[1:0];
         if (w_wr && address == 3'd3) r_ctrl <= writedata[1:0];
         r_edge <= (r_edge & ~w_edgeClr) | w_edgeDet;
         if (|(w_edgeDet & r_edge)) begin
            r_overrun <= 1'b1;
         end else if (w_ovClr) begin
            r_overrun <= 1'b0;
         end
         irq <= |w_pend;
      end
   end

`ifdef USB_EVT_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] r_tsCnt;
   logic [TS_WIDTH-1:0] r_tsInt;
   logic [TS_WIDTH-1:0] r_tsGpx;

   // Timestamps latch only on a 0->1 EDGE transition. This keeps the first
   // event's time until software clears the bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tsCnt <= '0;
         r_tsInt <= '0;
         r_tsGpx <= '0;
      end else begin
         r_tsCnt <= r_tsCnt + TS_WIDTH'(1);
         if (w_edgeDet[0] && !r_edge[0]) r_tsInt <= r_tsCnt;
         if (w_edgeDet[1] && !r_edge[1]) r_tsGpx <= r_tsCnt;
      end
   end
`else
   localparam int unusedTsWidth = TS_WIDTH;
`endif

   // Read multiplexer; unused bits and unbuilt registers read 0.
   always_comb begin
      w_rdMux = 32'd0;
      case (address)
         3'd0: w_rdMux[1:0] = r_level;
         3'd1: w_rdMux[1:0] = r_mask;
         3'd2: w_rdMux[1:0] = r_edge;
         3'd3: w_rdMux[1:0] = r_ctrl;
         3'd4: w_rdMux[3:0] = {r_overrun, w_id, |w_pend};
`ifdef USB_EVT_TIMESTAMP_EN
         3'd5: w_rdMux = 32'(r_tsInt);
         3'd6: w_rdMux = 32'(r_tsGpx);
`endif
         default: w_rdMux = 32'd0;
      endcase
   end

   // readdata updates only on a read and holds otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 32'd0;
      end else if (w_rd) begin
         readdata <= w_rdMux;
      end
   end

endmodule

// File: tb/tb_usb_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usb_event_ctrl
//
// Directed testbench for usb_event_ctrl with FILTER_CYCLES = 4.
// Register reads use a scoreboard: the expected value is queued when the read
// is issued and popped when readdata returns one clock later. irq and the
// other outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_usb_event_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        usb_int;
   logic        usb_gpx;
   logic [2:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [31:0] tsExp;
   logic [31:0] expQ [$];
   string       tagQ [$];

   usb_event_ctrl #(.FILTER_CYCLES(4), .TS_WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .usb_int    (usb_int),
      .usb_gpx    (usb_gpx),
      .address    (address),
      .chipselect (chipselect),
      .read       (read),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle 1ns past the edge. cyc counts the edges
   // since reset release, which is the free-running timestamp value.
   task automatic tick();
      @(posedge clk);
      if (reset_n) cyc++;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic intVal, input logic gpxVal,
                                input int holdCycles);
      usb_int = intVal;
      usb_gpx = gpxVal;
      repeat (holdCycles) tick();
   endtask

   task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic readReg(input logic [2:0] a, input logic [31:0] exp,
                          input string tag);
      expQ.push_back(exp);
      tagQ.push_back(tag);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a;
      tick();
      chipselect = 1'b0;
      read       = 1'b0;
      checkOutput(tagQ.pop_front(), readdata, expQ.pop_front());
   endtask

   initial begin
      reset_n    = 1'b0;
      usb_int    = 1'b0;
      usb_gpx    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      read       = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      tsExp      = 32'd0;
      repeat (3) tick();
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      checkOutput("rst_rdata", readdata, 32'd0);
      reset_n = 1'b1;
      cyc     = 0;

      // Register values after reset.
      readReg(3'd0, 32'd0, "level_rst");
      readReg(3'd1, 32'd0, "mask_rst");
      readReg(3'd2, 32'd0, "edge_rst");
      readReg(3'd3, 32'd0, "ctrl_rst");
      readReg(3'd4, 32'd0, "status_rst");
      writeReg(3'd1, 32'd3);
      readReg(3'd1, 32'd3, "mask_rw");

      // INT latency: level at +6, EDGE at +7, irq at +8 clocks.
      usb_int    = 1'b1;
      chipselect = 1'b1;
      read       = 1'b1;
      address    = 3'd0;
      repeat (6) tick();
      checkOutput("level_before_6", readdata, 32'd0);
      tick();
      checkOutput("level_at_6", readdata, 32'd1);
      checkOutput("irq_at_7", {31'd0, irq}, 32'd0);
      address = 3'd2;
      tick();
      checkOutput("edge_at_7", readdata, 32'd1);
      checkOutput("irq_at_8", {31'd0, irq}, 32'd1);
      chipselect = 1'b0;
      read       = 1'b0;

      // Clear INT. A 3-clock GPX glitch is rejected; a 5-clock pulse passes.
      writeReg(3'd2, 32'd1);
      tick();
      checkOutput("irq_after_clr", {31'd0, irq}, 32'd0);
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd0, 32'd1, "level_glitch");
      readReg(3'd2, 32'd0, "edge_glitch");
      checkOutput("irq_glitch", {31'd0, irq}, 32'd0);
      applyStimulus(1'b1, 1'b1, 5);
      applyStimulus(1'b1, 1'b0, 12);
      readReg(3'd2, 32'd2, "edge_pulse5");
      readReg(3'd4, 32'd3, "status_gpx");
      checkOutput("irq_gpx", {31'd0, irq}, 32'd1);

      // Falling-edge polarity on GPX only.
      writeReg(3'd2, 32'd2);
      writeReg(3'd3, 32'd2);
      readReg(3'd3, 32'd2, "ctrl_rw");
      applyStimulus(1'b1, 1'b1, 10);
      readReg(3'd2, 32'd0, "edge_rise_ignored");
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd2, 32'd2, "edge_fall");

      // Priority and irq drop after the last enabled bit clears.
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd2, 32'd3, "edge_both");
      readReg(3'd4, 32'd1, "status_int_pri");
      writeReg(3'd2, 32'd1);
      readReg(3'd4, 32'd3, "status_gpx_only");
      checkOutput("irq_still_set", {31'd0, irq}, 32'd1);
      writeReg(3'd2, 32'd2);
      checkOutput("irq_hold_1clk", {31'd0, irq}, 32'd1);
      tick();
      checkOutput("irq_dropped", {31'd0, irq}, 32'd0);

      // An edge and a W1C in the same cycle: the set wins.
      applyStimulus(1'b0, 1'b0, 10);
      usb_int = 1'b1;
      repeat (6) tick();
      writeReg(3'd2, 32'd1);
      readReg(3'd2, 32'd1, "edge_set_wins");
      readReg(3'd4, 32'd1, "status_no_ovr");

      // An edge while the bit is already set raises overrun.
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd4, 32'd9, "status_ovr");
      writeReg(3'd4, 32'd8);
      readReg(3'd4, 32'd1, "status_ovr_clr");

      // Reset during GPX filtering clears everything asynchronously.
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("irq_pre_rst", {31'd0, irq}, 32'd1);
      applyStimulus(1'b0, 1'b1, 3);
      reset_n = 1'b0;
      #1;
      checkOutput("irq_async_rst", {31'd0, irq}, 32'd0);
      checkOutput("rdata_async_rst", readdata, 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      cyc     = 0;
      readReg(3'd0, 32'd0, "level_after_rst");
      readReg(3'd1, 32'd0, "mask_after_rst");
      readReg(3'd4, 32'd0, "status_after_rst");
      applyStimulus(1'b0, 1'b1, 8);
      readReg(3'd2, 32'd2, "edge_softrst_gpx");

      // Fresh reset with both pins low for the timestamp checks.
      applyStimulus(1'b0, 1'b0, 10);
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      cyc     = 0;
`ifdef USB_EVT_TIMESTAMP_EN
      repeat (94) tick();
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd5, 32'h64, "ts_int_first");
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd5, 32'h64, "ts_int_held");
      writeReg(3'd2, 32'd1);
      applyStimulus(1'b0, 1'b0, 10);
      tsExp = 32'(cyc + 6);
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd5, tsExp, "ts_int_relatch");
      readReg(3'd6, 32'd0, "ts_gpx_idle");
`else
      applyStimulus(1'b1, 1'b0, 10);
      readReg(3'd2, 32'd1, "edge_int_nots");
      readReg(3'd5, 32'd0, "ts_int_absent");
      readReg(3'd6, 32'd0, "ts_gpx_absent");
`endif
      readReg(3'd7, 32'd0, "reserved");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
